// File: rtl/pa_hop_ctrl_pkg.sv
// Shared definitions for the hop scheduler and the pipelined phase accumulator.
package pa_hop_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SYNC  = 2'd1,
      ST_RUN   = 2'd2,
      ST_FLUSH = 2'd3
   } hop_state_e;

   localparam int PA_SLICES = 4;
   localparam int PA_FCW_W  = 4 * PA_SLICES;
   localparam int PA_LAT    = PA_SLICES;

endpackage

// File: rtl/pa_align_pipe.sv
// LAT-deep register chain that delays {wen, hop_start, idx} to line up with the
// accumulator's phase output.
module pa_align_pipe #(
   parameter int W   = 5,
   parameter int LAT = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] chain_p [LAT];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LAT; i++) chain_p[i] <= '0;
      end else begin
         chain_p[0] <= din;
         for (int i = 1; i < LAT; i++) chain_p[i] <= chain_p[i-1];
      end
   end

   assign dout = chain_p[LAT-1];

endmodule

// File: rtl/pa_hop_ctrl.sv
// Frequency-hop scheduler: steps a table of {FCW, dwell} entries into the phase
// accumulator and emits valid/hop strobes aligned to the accumulator output.
module pa_hop_ctrl
   import pa_hop_ctrl_pkg::*;
#(
   parameter int FCW_W   = PA_FCW_W,
   parameter int DEPTH   = 8,
   parameter int AW      = 3,
   parameter int DWELL_W = 16,
   parameter int LAT     = PA_LAT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_we,
   input  logic [AW-1:0]      cfg_addr,
   input  logic [FCW_W-1:0]   cfg_fcw,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic [AW-1:0]      cfg_last,
   input  logic               cfg_loop,
   output logic               cfg_ready,
   input  logic               start,
   input  logic               stop,
   output logic [FCW_W-1:0]   pa_fcw,
   output logic               pa_wen,
   output logic               pa_rst_n,
   output logic               phase_valid,
   output logic               hop_strobe,
   output logic [AW-1:0]      hop_idx,
   output logic               busy,
   output logic               done
);

   localparam int FLW = $clog2(LAT + 1);
   localparam logic [FLW-1:0] FLUSH_LOAD = FLW'(LAT - 1);
   localparam int PW = AW + 2;

   logic [FCW_W-1:0]   tab_fcw   [DEPTH];
   logic [DWELL_W-1:0] tab_dwell [DEPTH];

   hop_state_e         state;
   logic [AW-1:0]      idx;
   logic [AW-1:0]      idx_nxt;
   logic [AW-1:0]      last_q;
   logic               loop_q;
   logic [DWELL_W-1:0] dwell_cnt;
   logic [FLW-1:0]     flush_cnt;
   logic               hop_first;
   logic [PW-1:0]      pipe_out;

   // A zero dwell still occupies one cycle, so the counter loads dwell-1 floored at 0.
   function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
      return (d == '0) ? '0 : d - 1'b1;
   endfunction

   assign idx_nxt = (idx == last_q) ? '0 : idx + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            tab_fcw[i]   <= '0;
            tab_dwell[i] <= '0;
         end
      end else if (cfg_we && cfg_ready) begin
         tab_fcw[cfg_addr]   <= cfg_fcw;
         tab_dwell[cfg_addr] <= cfg_dwell;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         idx       <= '0;
         last_q    <= '0;
         loop_q    <= 1'b0;
         dwell_cnt <= '0;
         flush_cnt <= '0;
         hop_first <= 1'b0;
         pa_fcw    <= '0;
         pa_wen    <= 1'b0;
         pa_rst_n  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cfg_ready <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               cfg_ready <= 1'b1;
               pa_rst_n  <= 1'b1;
               pa_wen    <= 1'b0;
               hop_first <= 1'b0;
               busy      <= 1'b0;
               if (start && !stop) begin
                  state     <= ST_SYNC;
                  last_q    <= cfg_last;
                  loop_q    <= cfg_loop;
                  idx       <= '0;
                  pa_rst_n  <= 1'b0;
                  cfg_ready <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            ST_SYNC: begin
               pa_rst_n <= 1'b1;
               if (stop) begin
                  state     <= ST_FLUSH;
                  flush_cnt <= FLUSH_LOAD;
               end else begin
                  state     <= ST_RUN;
                  pa_wen    <= 1'b1;
                  pa_fcw    <= tab_fcw[0];
                  hop_first <= 1'b1;
                  dwell_cnt <= dwell_load(tab_dwell[0]);
               end
            end
            ST_RUN: begin
               hop_first <= 1'b0;
               if (stop) begin
                  state     <= ST_FLUSH;
                  pa_wen    <= 1'b0;
                  flush_cnt <= FLUSH_LOAD;
               end else if (dwell_cnt == '0) begin
                  if (idx == last_q && !loop_q) begin
                     state     <= ST_FLUSH;
                     pa_wen    <= 1'b0;
                     flush_cnt <= FLUSH_LOAD;
                  end else begin
                     idx       <= idx_nxt;
                     pa_fcw    <= tab_fcw[idx_nxt];
                     dwell_cnt <= dwell_load(tab_dwell[idx_nxt]);
                     hop_first <= 1'b1;
                  end
               end else begin
                  dwell_cnt <= dwell_cnt - 1'b1;
               end
            end
            ST_FLUSH: begin
               // Wait out the accumulator latency so the last valid sample leaves first.
               if (flush_cnt == '0) begin
                  state     <= ST_IDLE;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  cfg_ready <= 1'b1;
               end else begin
                  flush_cnt <= flush_cnt - 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   pa_align_pipe #(
      .W   (PW),
      .LAT (LAT)
   ) u_align (
      .clk   (clk),
      .reset (reset),
      .din   ({pa_wen, hop_first, idx}),
      .dout  (pipe_out)
   );

   assign {phase_valid, hop_strobe, hop_idx} = pipe_out;

endmodule
